// File: rtl/mmu_pkg.sv
// Shared defaults and types for the MMU feeder: array geometry, latency and FSM encoding.
package mmu_pkg;

  localparam int DEPTH     = 4;
  localparam int BIT_WIDTH = 8;
  localparam int SIZE      = 4;
  localparam int MMU_LAT   = 5;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    COLLECT = 3'd1,
    LOAD    = 3'd2,
    STREAM  = 3'd3,
    DRAIN   = 3'd4
  } state_t;

  typedef logic [BIT_WIDTH-1:0] lane_t;

  // Bubbles needed after the last beat until its final tag has left lane size-1.
  function automatic int drain_len(input int size, input int lat);
    return size - 1 + lat + 1;
  endfunction

endpackage

// File: rtl/mmu_skew_line.sv
// N-stage registered delay line with synchronous clear; one per data lane and per tag lane.
module mmu_skew_line #(
  parameter int W = 8,
  parameter int N = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_pipe [N];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) r_pipe[i] <= '0;
    end else begin
      r_pipe[0] <= i_d;
      for (int i = 1; i < N; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign o_q = r_pipe[N-1];

endmodule

// File: rtl/mmu_feeder.sv
// Initiator front end for the 4x4 weight-stationary MMU: buffers a weight tile, shifts it in,
// then streams skewed activations with per-lane result-valid tags.
//
// state   | meaning
// IDLE    | one cycle between tiles, no handshakes open
// COLLECT | accepting weight beats into wbuf
// LOAD    | shifting wbuf into the array, last-collected row first
// STREAM  | accepting activations, bubbles pushed on idle cycles
// DRAIN   | flushing skew and tag pipes before the next weight load
module mmu_feeder #(
  parameter int depth     = mmu_pkg::DEPTH,
  parameter int bit_width = mmu_pkg::BIT_WIDTH,
  parameter int size      = mmu_pkg::SIZE,
  parameter int MMU_LAT   = mmu_pkg::MMU_LAT
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wt_valid,
  output logic                       wt_ready,
  input  logic [bit_width*depth-1:0] wt_data,
  input  logic                       act_valid,
  output logic                       act_ready,
  input  logic [bit_width*depth-1:0] act_data,
  input  logic                       act_last,
  output logic                       control,
  output logic [bit_width*depth-1:0] wt_arr,
  output logic [bit_width*depth-1:0] data_arr,
  output logic [size-1:0]            lane_valid,
  output logic                       busy,
  output logic                       tile_done
);

  import mmu_pkg::*;

  localparam int WW   = bit_width * depth;
  localparam int CW   = $clog2(size) + 1;
  localparam int AW   = $clog2(size);
  localparam int DLEN = drain_len(size, MMU_LAT);
  localparam int DW   = $clog2(size + MMU_LAT) + 1;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_nxt;
  logic [DW-1:0]   r_dcnt;
  logic [DW-1:0]   w_dcnt_nxt;
  logic [WW-1:0]   r_wbuf [size];

  logic            r_wt_ready;
  logic            r_act_ready;
  logic            r_control;
  logic [WW-1:0]   r_wt_arr;
  logic            r_busy;
  logic            r_tile_done;

  logic            w_wt_acc;
  logic            w_act_acc;
  logic [AW-1:0]   w_load_idx;
  logic [WW-1:0]   w_load_word;
  logic [WW-1:0]   w_push_data;
  logic            w_push_tag;

  assign w_wt_acc  = wt_valid  & r_wt_ready  & (r_state == COLLECT);
  assign w_act_acc = act_valid & r_act_ready & (r_state == STREAM);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_dcnt_nxt  = r_dcnt;
    case (r_state)
      IDLE: begin
        w_state_nxt = COLLECT;
        w_cnt_nxt   = '0;
      end
      COLLECT: begin
        if (w_wt_acc) begin
          if (r_cnt == CW'(size - 1)) begin
            w_state_nxt = LOAD;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end
      LOAD: begin
        if (r_cnt == CW'(size - 1)) begin
          w_state_nxt = STREAM;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      STREAM: begin
        if (w_act_acc && act_last) begin
          w_state_nxt = DRAIN;
          w_dcnt_nxt  = '0;
        end
      end
      DRAIN: begin
        if (r_dcnt == DW'(DLEN - 1)) begin
          w_state_nxt = IDLE;
          w_dcnt_nxt  = '0;
        end else begin
          w_dcnt_nxt = r_dcnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
        w_dcnt_nxt  = '0;
      end
    endcase
  end

  // Outputs are registered from next-state values; the last weight beat is forwarded
  // because it lands in wbuf on the same edge that opens LOAD.
  assign w_load_idx  = AW'(size - 1) - w_cnt_nxt[AW-1:0];
  assign w_load_word = (w_wt_acc && (r_cnt[AW-1:0] == w_load_idx)) ? wt_data
                                                                   : r_wbuf[w_load_idx];

  always_ff @(posedge clk) begin
    if (w_wt_acc) r_wbuf[r_cnt[AW-1:0]] <= wt_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_dcnt      <= '0;
      r_wt_ready  <= 1'b0;
      r_act_ready <= 1'b0;
      r_control   <= 1'b0;
      r_wt_arr    <= '0;
      r_busy      <= 1'b0;
      r_tile_done <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_dcnt      <= w_dcnt_nxt;
      r_wt_ready  <= (w_state_nxt == COLLECT);
      r_act_ready <= (w_state_nxt == STREAM);
      r_control   <= (w_state_nxt == LOAD);
      r_wt_arr    <= (w_state_nxt == LOAD) ? w_load_word : '0;
      r_busy      <= (w_state_nxt != IDLE);
      r_tile_done <= (w_state_nxt == DRAIN) && (w_dcnt_nxt == DW'(DLEN - 1));
    end
  end

  assign w_push_data = w_act_acc ? act_data : '0;
  assign w_push_tag  = w_act_acc;

  for (genvar k = 0; k < depth; k++) begin : g_data
    mmu_skew_line #(.W(bit_width), .N(k + 1)) u_line (
      .clk (clk),
      .rst (rst),
      .i_d (w_push_data[k*bit_width +: bit_width]),
      .o_q (data_arr[k*bit_width +: bit_width])
    );
  end

  // Tags travel on their own lines so a bubble can never be reported as a result.
  for (genvar k = 0; k < size; k++) begin : g_tag
    mmu_skew_line #(.W(1), .N(k + 1 + MMU_LAT)) u_line (
      .clk (clk),
      .rst (rst),
      .i_d (w_push_tag),
      .o_q (lane_valid[k])
    );
  end

  assign wt_ready  = r_wt_ready;
  assign act_ready = r_act_ready;
  assign control   = r_control;
  assign wt_arr    = r_wt_arr;
  assign busy      = r_busy;
  assign tile_done = r_tile_done;

endmodule

// File: tb/tb_mmu_feeder.sv
// Directed bench for mmu_feeder with a cycle-stamped scoreboard and a behavioural MMU model.
module tb_mmu_feeder;
  import mmu_pkg::*;

  typedef logic [31:0] tile_t [SIZE];
  typedef struct {
    int          kind;
    int          lane;
    int          due;
    logic [31:0] val;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wt_valid = 1'b0;
  logic [31:0] wt_data = '0;
  logic        act_valid = 1'b0;
  logic [31:0] act_data = '0;
  logic        act_last = 1'b0;
  logic        wt_ready, act_ready, control, busy, tile_done;
  logic [31:0] wt_arr, data_arr;
  logic [SIZE-1:0] lane_valid;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic e2e_on = 1'b0;

  tile_t       sent_w;
  logic [31:0] wm [SIZE];
  logic [31:0] hist [4096];
  logic [31:0] wt_q [$];
  ent_t        sb [$];
  ent_t        keep [$];

  logic [31:0]     exp_d;
  logic [SIZE-1:0] exp_v;
  logic [31:0]     exp_a [SIZE];
  logic [31:0]     ew;

  always #5 clk = ~clk;

  mmu_feeder dut (
    .clk        (clk),
    .rst        (rst),
    .wt_valid   (wt_valid),
    .wt_ready   (wt_ready),
    .wt_data    (wt_data),
    .act_valid  (act_valid),
    .act_ready  (act_ready),
    .act_data   (act_data),
    .act_last   (act_last),
    .control    (control),
    .wt_arr     (wt_arr),
    .data_arr   (data_arr),
    .lane_valid (lane_valid),
    .busy       (busy),
    .tile_done  (tile_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Result the array should produce for the beat now on act_data, using the weights we sent.
  function automatic logic [31:0] exp_acc(input int k);
    logic [31:0] s = '0;
    for (int i = 0; i < SIZE; i++)
      s += 32'(act_data[8*i +: 8]) * 32'(sent_w[i][8*k +: 8]);
    return s;
  endfunction

  // Behavioural MMU: column k sums weight(i,k) times data lane i as it passed the array.
  function automatic logic [31:0] mmu_acc(input int k);
    logic [31:0] s = '0;
    logic [31:0] a;
    for (int i = 0; i < SIZE; i++) begin
      a = hist[12'(cyc - MMU_LAT - k + i)];
      s += 32'(wm[i][8*k +: 8]) * 32'(a[8*i +: 8]);
    end
    return s;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      sb.delete();
      wt_q.delete();
    end else begin
      if (wt_valid && wt_ready) wt_q.push_back(wt_data);
      if (act_valid && act_ready) begin
        for (int k = 0; k < SIZE; k++) begin
          sb.push_back('{0, k, cyc + 1 + k, {24'h0, act_data[8*k +: 8]}});
          sb.push_back('{1, k, cyc + 1 + k + MMU_LAT, exp_acc(k)});
        end
      end
    end
    cyc = cyc + 1;
  end

  always @(negedge clk) begin
    exp_d = '0;
    exp_v = '0;
    for (int k = 0; k < SIZE; k++) exp_a[k] = '0;
    hist[12'(cyc)] = data_arr;
    keep.delete();
    foreach (sb[i]) begin
      if (sb[i].due == cyc) begin
        if (sb[i].kind == 0) exp_d[8*sb[i].lane +: 8] = sb[i].val[7:0];
        else begin
          exp_v[sb[i].lane] = 1'b1;
          exp_a[sb[i].lane] = sb[i].val;
        end
      end else if (sb[i].due > cyc) begin
        keep.push_back(sb[i]);
      end
    end
    sb = keep;
    chk("data_arr", data_arr, exp_d);
    chk("lane_valid", 32'(lane_valid), 32'(exp_v));
    if (e2e_on) begin
      for (int k = 0; k < SIZE; k++)
        if (exp_v[k]) chk("acc_out", mmu_acc(k), exp_a[k]);
    end
    if (control) begin
      ew = 32'hBAD0BAD0;
      if (wt_q.size() > 0) ew = wt_q.pop_back();
      chk("wt_arr", wt_arr, ew);
      for (int i = SIZE - 1; i > 0; i--) wm[i] = wm[i-1];
      wm[0] = wt_arr;
    end
  end

  task automatic chk_reset();
    chk("rst_control", 32'(control), 32'd0);
    chk("rst_wt_arr", wt_arr, 32'd0);
    chk("rst_data_arr", data_arr, 32'd0);
    chk("rst_lane_valid", 32'(lane_valid), 32'd0);
    chk("rst_tile_done", 32'(tile_done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_wt_ready", 32'(wt_ready), 32'd0);
    chk("rst_act_ready", 32'(act_ready), 32'd0);
  endtask

  task automatic send_wt(input logic [31:0] d);
    int n = 0;
    wt_valid = 1'b1;
    wt_data  = d;
    while (!wt_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("wt_handshake", 32'(wt_ready), 32'd1);
    @(negedge clk);
    wt_valid = 1'b0;
  endtask

  task automatic send_wts(input tile_t w, input bit gap);
    sent_w = w;
    for (int i = 0; i < SIZE; i++) begin
      send_wt(w[i]);
      if (gap && i < SIZE - 1) @(negedge clk);
    end
  endtask

  // Entered on the first LOAD cycle; a stray wt_valid is held up to prove it is ignored.
  task automatic check_load(input logic [31:0] junk);
    wt_valid = 1'b1;
    wt_data  = junk;
    for (int j = 0; j < SIZE; j++) begin
      chk("control_load", 32'(control), 32'd1);
      chk("wt_ready_load", 32'(wt_ready), 32'd0);
      chk("act_ready_load", 32'(act_ready), 32'd0);
      @(negedge clk);
    end
    wt_valid = 1'b0;
    chk("control_stream", 32'(control), 32'd0);
    chk("act_ready_stream", 32'(act_ready), 32'd1);
  endtask

  task automatic send_act(input logic [31:0] d, input bit last, output int t);
    int n = 0;
    act_valid = 1'b1;
    act_data  = d;
    act_last  = last;
    while (!act_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("act_handshake", 32'(act_ready), 32'd1);
    t = cyc;
    @(negedge clk);
    act_valid = 1'b0;
    act_last  = 1'b0;
    act_data  = '0;
    if (last) chk("act_ready_drain", 32'(act_ready), 32'd0);
  endtask

  task automatic wait_done(input int t_last);
    int n = 0;
    while (!tile_done && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("tile_done_seen", 32'(tile_done), 32'd1);
    chk("tile_done_cycle", cyc, t_last + SIZE + MMU_LAT);
    @(negedge clk);
    chk("tile_done_pulse", 32'(tile_done), 32'd0);
    chk("busy_idle", 32'(busy), 32'd0);
    chk("wt_ready_idle", 32'(wt_ready), 32'd0);
    @(negedge clk);
    chk("busy_collect", 32'(busy), 32'd1);
    chk("wt_ready_collect", 32'(wt_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    tile_t w_a;
    tile_t w_id;
    int t;
    w_a  = '{32'h04030201, 32'h08070605, 32'h0C0B0A09, 32'h100F0E0D};
    w_id = '{32'h00000001, 32'h00000100, 32'h00010000, 32'h01000000};

    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk_reset();
    rst = 1'b0;
    @(negedge clk);
    chk("busy_after_rst", 32'(busy), 32'd1);
    chk("wt_ready_after_rst", 32'(wt_ready), 32'd1);

    // single-beat tile
    send_wts(w_a, 1'b0);
    check_load(32'hDEADBEEF);
    send_act(32'h44332211, 1'b1, t);
    wait_done(t);

    // three beats with a two-cycle hole between the first and second
    send_wts(w_a, 1'b0);
    check_load(32'hCAFEF00D);
    send_act(32'hA4A3A2A1, 1'b0, t);
    repeat (2) @(negedge clk);
    send_act(32'hB4B3B2B1, 1'b0, t);
    send_act(32'hC4C3C2C1, 1'b1, t);
    wait_done(t);

    // weight beats with a bubble after each
    send_wts('{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444}, 1'b1);
    check_load(32'h55555555);
    send_act(32'h0D0C0B0A, 1'b1, t);
    wait_done(t);

    // reset in the middle of streaming, then a clean tile
    send_wts(w_a, 1'b0);
    check_load(32'h0);
    send_act(32'h99887766, 1'b0, t);
    rst = 1'b1;
    @(negedge clk);
    chk_reset();
    rst = 1'b0;
    @(negedge clk);
    chk("wt_ready_after_abort", 32'(wt_ready), 32'd1);
    send_wts(w_a, 1'b0);
    check_load(32'hDEADBEEF);
    send_act(32'h44332211, 1'b1, t);
    wait_done(t);

    // identity weights through the array model
    e2e_on = 1'b1;
    send_wts(w_id, 1'b0);
    check_load(32'h0);
    send_act(32'h04030201, 1'b1, t);
    wait_done(t);
    e2e_on = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
